// File: rtl/uart_rcvr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_rcvr
//  Brief    : Oversampled async serial receiver, 3-sample majority per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rcvr #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 2,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  serial_i,
    input  logic                  sample_tick_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] c_mid       = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] c_mid_m1    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_decide    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] c_last_tick = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_last_bit  = BW'(DATA_WIDTH - 1);
    localparam logic          c_last_stop = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t r_state, w_state_next;

    logic                  r_sync1, r_sync2;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_armed;
    logic                  r_err;
    logic                  r_samp0, r_samp1;
    logic [DATA_WIDTH-1:0] r_shreg;

    logic w_rx_s, w_decide, w_maj, w_err_next, w_frame_end;

    assign w_rx_s     = r_sync2;
    assign w_decide   = sample_tick_i && (r_tick_cnt == c_decide);
    assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);
    assign w_err_next = r_err | ~w_maj;

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (sample_tick_i && !w_rx_s && r_armed)
                    w_state_next = RX_START;
            end
            RX_START: begin
                busy_o = 1'b1;
                if (w_decide)
                    w_state_next = w_maj ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                busy_o = 1'b1;
                if (w_decide && (r_bit_cnt == c_last_bit))
                    w_state_next = RX_STOP;
            end
            RX_STOP: begin
                busy_o = 1'b1;
                if (w_decide && (r_stop_cnt == c_last_stop)) begin
                    w_state_next = RX_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= RX_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_armed     <= 1'b1;
            r_err       <= 1'b0;
            r_samp0     <= 1'b1;
            r_samp1     <= 1'b1;
            r_shreg     <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            r_sync1     <= serial_i;
            r_sync2     <= r_sync1;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (sample_tick_i) begin
                if (r_state == RX_IDLE) begin
                    // The start-detect tick is tick 0 of the start bit.
                    r_tick_cnt <= '0;
                    if (w_rx_s) r_armed <= 1'b1;
                end else begin
                    r_tick_cnt <= (r_tick_cnt == c_last_tick) ? '0 : r_tick_cnt + 1'b1;
                    if (r_tick_cnt == c_mid_m1) r_samp0 <= w_rx_s;
                    if (r_tick_cnt == c_mid)    r_samp1 <= w_rx_s;
                end
            end
            if (w_decide) begin
                case (r_state)
                    RX_START: r_bit_cnt <= '0;
                    RX_DATA: begin
                        r_shreg   <= {w_maj, r_shreg[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_stop_cnt <= 1'b0;
                            r_err      <= 1'b0;
                        end
                    end
                    RX_STOP: begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                        r_err      <= w_err_next;
                    end
                    default: ;
                endcase
            end
            if (w_frame_end) begin
                rx_data_o   <= r_shreg;
                rx_valid_o  <= ~w_err_next;
                frame_err_o <= w_err_next;
                // A bad frame (e.g. a break) must see the line high before re-arming.
                if (w_err_next) r_armed <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rcvr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rcvr
//  Brief    : Directed + randomized frames against a frame-level event model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rcvr;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       serial_i = 1'b1;
    logic       sample_tick_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, busy_o;

    int tests = 0;
    int fails = 0;

    // Each received/expected event: {frame_err, data}
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    uart_rcvr #(.DATA_WIDTH(8), .STOP_BITS(2), .OVERSAMPLE(OS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .serial_i     (serial_i),
        .sample_tick_i(sample_tick_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_tick_i = 1'b1;
            @(negedge clk);
            sample_tick_i = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni && (rx_valid_o || frame_err_o)) begin
                got_q.push_back({frame_err_o, rx_data_o});
                check("pulse_exclusive", 32'(rx_valid_o & frame_err_o), 32'd0);
                check("busy_at_pulse", 32'(busy_o), 32'd0);
            end
        end
    end

    task automatic line(input logic v, input int ticks);
        serial_i = v;
        repeat (ticks * 4) @(negedge clk);
    endtask

    // stops[i] is the level of stop bit i; noise_bit < 0 means no noise.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] stops, input int noise_bit);
        line(1'b0, OS);
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == noise_bit) begin
                line(d[i], 8);
                line(~d[i], 1);
                line(d[i], 7);
            end else begin
                line(d[i], OS);
            end
        end
        line(stops[0], OS);
        line(stops[1], OS);
        serial_i = 1'b1;
        exp_q.push_back({~&stops, d});
    endtask

    task automatic compare(string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] st;
        int         nz;
        logic [7:0] partial;

        #12;
        check("reset_data", 32'(rx_data_o), 32'd0);
        check("reset_valid", 32'(rx_valid_o), 32'd0);
        check("reset_ferr", 32'(frame_err_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        line(1'b1, 2 * OS);

        // clean frame
        send_frame(8'hA5, 2'b11, -1);
        line(1'b1, OS);
        compare("t1_a5");
        check("t1_data", 32'(rx_data_o), 32'hA5);

        // short low glitch is a false start
        line(1'b0, 4);
        line(1'b1, 2 * OS);
        check("t2_busy_idle", 32'(busy_o), 32'd0);
        compare("t2_glitch");
        send_frame(8'h3C, 2'b11, -1);
        line(1'b1, OS);
        compare("t2_3c");

        // bad second stop bit
        send_frame(8'h3C, 2'b01, -1);
        line(1'b1, OS);
        compare("t3_ferr");
        check("t3_data", 32'(rx_data_o), 32'h3C);

        // break: one framing error, then a good frame once re-armed
        line(1'b0, 30 * OS);
        line(1'b1, 2 * OS);
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h55, 2'b11, -1);
        line(1'b1, OS);
        compare("t4_break");

        // back-to-back with single-tick noise in bit 3 of the middle frame
        send_frame(8'h00, 2'b11, -1);
        send_frame(8'hFF, 2'b11, 3);
        send_frame(8'h81, 2'b11, -1);
        line(1'b1, OS);
        compare("t5_b2b");

        // asynchronous reset in the middle of data bit 4
        partial = 8'hF0;
        line(1'b0, OS);
        for (int i = 0; i < 4; i++) line(partial[i], OS);
        line(partial[4], 8);
        #3;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_data", 32'(rx_data_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_valid", 32'(rx_valid_o), 32'd0);
        check("t6_rst_ferr", 32'(frame_err_o), 32'd0);
        serial_i = 1'b1;
        repeat (10) @(negedge clk);
        rst_ni = 1'b1;
        line(1'b1, 2 * OS);
        send_frame(8'h81, 2'b11, -1);
        line(1'b1, OS);
        compare("t6_after_rst");

        // randomized frames: random data, occasional bad stop bits, random noise and gaps
        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            nz = int'($urandom_range(0, 8));
            if (nz == 8) nz = -1;
            send_frame(d, st, nz);
            if (st != 2'b11) line(1'b1, 1 + int'($urandom_range(0, 2)) * OS);
            else             line(1'b1, int'($urandom_range(0, 2)) * OS);
        end
        line(1'b1, OS);
        compare("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
